// File: rtl/decode_pkg.sv
// decode_pkg: opcode/func codes, ALU op enum, class bit indices and the decoded bundle type
package decode_pkg;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam int CLS_R  = 4;
  localparam int CLS_I  = 3;
  localparam int CLS_J  = 2;
  localparam int CLS_LD = 1;
  localparam int CLS_ST = 0;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_e;
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [15:0] imm;
    logic        zext;
    logic        rd_rt;
    alu_op_e     alu_op;
    logic [4:0]  cls;
    logic        cond;
    logic        illegal;
  } decoded_t;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational decode of inst (32b) into decoded_t d (fields, class, alu op, imm, illegal)
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    d
);
  logic [5:0] op, fn;
  logic is_r, is_ld, is_st, is_j, is_br, is_ia, is_i, r_ok;
  alu_op_e r_op, i_op;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign is_r = op == OP_R;
  assign is_ld = op == OP_LW;
  assign is_st = op == OP_SW;
  assign is_j = op[5:1] == 5'b00001;
  assign is_br = op[5:1] == 5'b00010;
  assign is_ia = op[5:3] == 3'b001;
  assign is_i = is_ia | is_br | is_ld | is_st;
  assign i_op = op[2] ? alu_op_e'({1'b0, op[1:0]}) : op[1:0] == 2'b00 ? ALU_ADD :
                op[1:0] == 2'b11 ? ALU_SLTU : ALU_AND;
  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_AND;
    casez (fn)
      F_ADD:     r_op = ALU_ADD;
      F_SUB:     r_op = ALU_SUB;
      6'b1001??: r_op = alu_op_e'({1'b0, fn[1:0]});
      F_SLTU:    r_op = ALU_SLTU;
      F_SLLV:    r_op = ALU_SLLV;
      default:   r_ok = 1'b0;
    endcase
  end
  always_comb begin
    d = '0;
    d.rs = is_j ? 5'd0 : inst[25:21];
    d.rt = is_j ? 5'd0 : inst[20:16];
    d.wr = is_r ? inst[15:11] : (is_ia | is_ld) ? inst[20:16] : 5'd0;
    d.imm = is_i ? inst[15:0] : 16'd0;
    d.zext = is_ia & (op[2] | op[1:0] == 2'b11);
    d.rd_rt = is_r | is_st | is_br;
    d.alu_op = is_r ? r_op : is_ia ? i_op : is_br ? ALU_XOR : (is_ld | is_st) ? ALU_ADD : ALU_AND;
    d.cls = {is_r, is_i, is_j, is_ld, is_st};
    d.cond = is_br | is_j;
    d.illegal = !(is_r | is_i | is_j) | (is_r & !r_ok);
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with valid/ready in (inst, in_pc) and out (out_*), flush, load scoreboard fed by wb_valid/wb_reg
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RAW    = $clog2(NREG),
  parameter int MAX_LD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [RAW-1:0]  out_rs,
  output logic [RAW-1:0]  out_rt,
  output logic [RAW-1:0]  out_wr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_alu_op,
  output logic [4:0]      out_cls,
  output logic            out_cond,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [RAW-1:0]  wb_reg
);
  localparam int CW = $clog2(MAX_LD + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LD);
  decoded_t d;
  logic [NREG-1:0] sb;
  logic [CW-1:0] cnt;
  logic open, stall, fire, ld_set, wb_clr, dec;
  decode_comb u_comb (.inst(inst), .d(d));
  assign open = !out_valid | out_ready;
  // hazard looks at the scoreboard before this cycle's writeback clears it
  assign stall = in_valid & ((sb[d.rs] & d.rs != 0) | (sb[d.rt] & d.rt != 0 & d.rd_rt) |
                             (d.cls[CLS_LD] & cnt == CMAX));
  assign in_ready = open & !stall & !flush & !rst;
  assign fire = in_valid & in_ready;
  assign ld_set = fire & d.cls[CLS_LD] & d.rt != 0;
  assign wb_clr = wb_valid & wb_reg != 0;
  assign dec = wb_clr & cnt != 0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_rs <= '0;
      out_rt <= '0;
      out_wr <= '0;
      out_imm <= '0;
      out_alu_op <= '0;
      out_cls <= '0;
      out_cond <= 1'b0;
      out_illegal <= 1'b0;
      sb <= '0;
      cnt <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (open) out_valid <= fire;
      if (fire) begin
        out_pc <= in_pc;
        out_rs <= d.rs;
        out_rt <= d.rt;
        out_wr <= d.wr;
        out_imm <= d.zext ? {{(XLEN-16){1'b0}}, d.imm} : {{(XLEN-16){d.imm[15]}}, d.imm};
        out_alu_op <= d.alu_op;
        out_cls <= d.cls;
        out_cond <= d.cond;
        out_illegal <= d.illegal;
      end
      // set after clear so a new load to the same register keeps its bit
      if (wb_clr) sb[wb_reg] <= 1'b0;
      if (ld_set) sb[d.rt] <= 1'b1;
      cnt <= cnt + CW'(ld_set) - CW'(dec);
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed stimulus checked against a behavioural decode/scoreboard model
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0;
  logic out_valid, out_ready = 1'b0, out_cond, out_illegal, wb_valid = 1'b0;
  logic [31:0] inst = '0, in_pc = '0, out_pc, out_imm;
  logic [4:0] out_rs, out_rt, out_wr, wb_reg = '0, out_cls;
  logic [2:0] out_alu_op;
  int checks = 0, fails = 0;
  localparam int MAX_LD = 4;
  typedef struct {
    logic [4:0] rs, rt, wr, cls;
    logic [31:0] imm;
    logic [2:0] alu;
    logic cond, ill, rrt, ld;
  } exp_t;
  exp_t m_out;
  logic [31:0] m_pc;
  logic m_valid;
  logic [31:0] sb_m;
  int cnt;
  logic [4:0] q[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs),
    .out_rt(out_rt), .out_wr(out_wr), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_cls(out_cls),
    .out_cond(out_cond), .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_reg(wb_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int op, fn;
    logic [31:0] sx, zx;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0, w[15:0]};
    e = '{default: 0};
    e.rs = w[25:21];
    e.rt = w[20:16];
    if (op == 0) begin
      e.cls = 5'b10000;
      e.wr = w[15:11];
      e.rrt = 1'b1;
      if (fn == 32) e.alu = 3'd4;
      else if (fn == 34) e.alu = 3'd5;
      else if (fn >= 36 && fn <= 39) e.alu = 3'(fn - 36);
      else if (fn == 43) e.alu = 3'd6;
      else if (fn == 4) e.alu = 3'd7;
      else e.ill = 1'b1;
    end else if (op == 35 || op == 43) begin
      e.cls = (op == 35) ? 5'b01010 : 5'b01001;
      e.alu = 3'd4;
      e.imm = sx;
      e.wr = (op == 35) ? w[20:16] : 5'd0;
      e.ld = (op == 35);
      e.rrt = (op == 43);
    end else if (op == 2 || op == 3) begin
      e.cls = 5'b00100;
      e.cond = 1'b1;
      e.rs = 5'd0;
      e.rt = 5'd0;
    end else if (op == 4 || op == 5) begin
      e.cls = 5'b01000;
      e.cond = 1'b1;
      e.alu = 3'd2;
      e.imm = sx;
      e.rrt = 1'b1;
    end else if (op >= 8 && op <= 15) begin
      e.cls = 5'b01000;
      e.wr = w[20:16];
      if (op == 8) begin e.alu = 3'd4; e.imm = sx; end
      else if (op == 9 || op == 10) begin e.alu = 3'd0; e.imm = sx; end
      else if (op == 11) begin e.alu = 3'd6; e.imm = zx; end
      else begin e.alu = 3'(op - 12); e.imm = zx; end
    end else e.ill = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [5:0] fl [9];
    int k;
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd43, 6'd4, 6'd1};
    w = $urandom;
    k = $urandom_range(0, 9);
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    case (k)
      0, 1: begin w[31:26] = 6'd0; w[5:0] = fl[$urandom_range(0, 8)]; end
      2, 3, 9: w[31:26] = 6'd35;
      4: w[31:26] = 6'd43;
      5: w[31:26] = 6'($urandom_range(2, 3));
      6: w[31:26] = 6'($urandom_range(4, 5));
      7: w[31:26] = 6'($urandom_range(8, 15));
      default: w[31:26] = 6'($urandom_range(0, 63));
    endcase
    return w;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic wv, input logic [4:0] wr);
    exp_t e;
    logic open, stall, rdy, fire;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rs", out_rs, m_out.rs);
      chk("out_rt", out_rt, m_out.rt);
      chk("out_wr", out_wr, m_out.wr);
      chk("out_imm", out_imm, m_out.imm);
      chk("out_alu_op", out_alu_op, m_out.alu);
      chk("out_cls", out_cls, m_out.cls);
      chk("out_cond", out_cond, m_out.cond);
      chk("out_illegal", out_illegal, m_out.ill);
    end
    rst = r; in_valid = iv; inst = ins; in_pc = $urandom; out_ready = ordy;
    flush = fl; wb_valid = wv; wb_reg = wr;
    #1;
    e = ref_decode(ins);
    if (r) begin
      chk("rst_in_ready", in_ready, 1'b0);
      m_valid = 1'b0; m_out = '{default: 0}; m_pc = '0; sb_m = '0; cnt = 0; q.delete();
    end else begin
      open = !m_valid || ordy;
      stall = iv && ((sb_m[e.rs] && e.rs != 0) || (sb_m[e.rt] && e.rt != 0 && e.rrt) ||
                     (e.ld && cnt == MAX_LD));
      rdy = open && !stall && !fl;
      chk("in_ready", in_ready, rdy);
      fire = iv && rdy;
      if (fl) m_valid = 1'b0;
      else if (open) m_valid = fire;
      if (fire) begin m_out = e; m_pc = in_pc; end
      if (wv && wr != 0) begin
        sb_m[wr] = 1'b0;
        if (cnt > 0) cnt--;
        foreach (q[i]) if (q[i] == wr) begin q.delete(i); break; end
      end
      if (fire && e.ld && e.rt != 0) begin sb_m[e.rt] = 1'b1; cnt++; q.push_back(e.rt); end
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lw_to(input int k);
    return {6'b100011, 5'd0, 5'(k), 16'd0};
  endfunction

  initial begin
    m_valid = 1'b0; m_out = '{default: 0}; m_pc = '0; sb_m = '0; cnt = 0;
    step(1, 1, 32'h00221820, 1, 0, 0, 0);
    step(1, 1, 32'h00221820, 1, 0, 1, 5'd3);
    post();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_cls", out_cls, 0);
    chk("rst_out_alu", out_alu_op, 0);
    step(0, 1, 32'h00221820, 1, 0, 0, 0);
    post();
    chk("add_valid", out_valid, 1'b1);
    chk("add_wr", out_wr, 5'd3);
    chk("add_alu", out_alu_op, 3'b100);
    chk("add_cls", out_cls, 5'b10000);
    chk("add_imm", out_imm, 0);
    step(0, 1, 32'h2001FFFF, 1, 0, 0, 0);
    post();
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_alu", out_alu_op, 3'b100);
    step(0, 1, 32'h3001FFFF, 1, 0, 0, 0);
    post();
    chk("andi_imm", out_imm, 32'h0000FFFF);
    chk("andi_alu", out_alu_op, 3'b000);
    step(0, 1, 32'hFC000000, 1, 0, 0, 0);
    post();
    chk("illegal_op", out_illegal, 1'b1);
    chk("illegal_cls", out_cls, 5'b00000);
    step(0, 1, 32'h8C250000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h00A53020, 1, 0, 0, 0);
      chk("luse_stall", in_ready, 1'b0);
    end
    step(0, 1, 32'h00A53020, 1, 0, 1, 5'd5);
    chk("luse_wb_cycle", in_ready, 1'b0);
    step(0, 1, 32'h00A53020, 1, 0, 0, 0);
    chk("luse_issue", in_ready, 1'b1);
    step(0, 1, 32'h00221820, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h2001FFFF, 0, 0, 0, 0);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 32'h2001FFFF, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 1, lw_to(k), 1, 0, 0, 0);
    step(0, 1, lw_to(7), 1, 0, 0, 0);
    chk("ld_full", in_ready, 1'b0);
    step(0, 1, lw_to(7), 1, 0, 1, 5'd1);
    chk("ld_full_wb", in_ready, 1'b0);
    step(0, 1, lw_to(7), 1, 0, 0, 0);
    chk("ld_after_wb", in_ready, 1'b1);
    step(0, 0, 0, 1, 0, 1, 5'd3);
    step(0, 1, lw_to(4), 1, 0, 1, 5'd4);
    step(0, 1, 32'h00803020, 1, 0, 0, 0);
    chk("sb_set_wins", in_ready, 1'b0);
    step(0, 1, 32'h00221820, 0, 0, 0, 0);
    step(0, 1, 32'h00221820, 0, 1, 0, 0);
    while (q.size() > 0) step(0, 0, 0, 1, 0, 1, q[0]);
    for (int i = 0; i < 3000; i++) begin
      logic wv;
      logic [4:0] wr;
      wv = 1'b0;
      wr = '0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1'b1;
        wr = q[$urandom_range(0, q.size() - 1)];
      end
      if (i == 1500) begin
        step(1, 1, rand_inst(), 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 5'd3);
      end else
        step(0, $urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 9) < 7,
             $urandom_range(0, 29) == 0, wv, wr);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
